// File: rtl/controle_barramento_if.sv
// Request handshake and per-port bus control lines of the bus sequencer.
// Ports: req_valid/req_ready/req_src/req_dst in, ctrl_0..ctrl_5 {escrever, ler} out.
interface controle_barramento_if;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_src;
  logic [2:0] req_dst;
  logic [1:0] ctrl_0;
  logic [1:0] ctrl_1;
  logic [1:0] ctrl_2;
  logic [1:0] ctrl_3;
  logic [1:0] ctrl_4;
  logic [1:0] ctrl_5;

  modport slave (
    input  req_valid,
    input  req_src,
    input  req_dst,
    output req_ready,
    output ctrl_0,
    output ctrl_1,
    output ctrl_2,
    output ctrl_3,
    output ctrl_4,
    output ctrl_5
  );

  modport master (
    output req_valid,
    output req_src,
    output req_dst,
    input  req_ready,
    input  ctrl_0,
    input  ctrl_1,
    input  ctrl_2,
    input  ctrl_3,
    input  ctrl_4,
    input  ctrl_5
  );
endinterface

// File: rtl/controle_barramento.sv
// Transfer sequencer for the 6-port shared bus: queues src->dst requests and
// times each one around the bus pipeline (ESCREVE, ESPERA, LE).
// Ports: clk, rst_n, bus (slave), ocupado, feito, erro, nivel_fila.
module controle_barramento #(
  parameter int PROFUNDIDADE_FILA = 4,
  parameter int LATENCIA_BUS      = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  controle_barramento_if.slave               bus,
  output logic                               ocupado,
  output logic                               feito,
  output logic                               erro,
  output logic [$clog2(PROFUNDIDADE_FILA):0] nivel_fila
);

  localparam int AW = $clog2(PROFUNDIDADE_FILA);
  localparam int CW = $clog2(LATENCIA_BUS) + 1;
  localparam logic [CW-1:0] CNT_INI =
    CW'((LATENCIA_BUS >= 2) ? LATENCIA_BUS - 2 : 0);
  localparam logic [AW:0] CHEIO = (AW+1)'(PROFUNDIDADE_FILA);

  typedef struct packed {
    logic [2:0] src;
    logic [2:0] dst;
  } pedido_t;

  typedef enum logic [1:0] {
    OCIOSO,
    ESCREVE,
    ESPERA,
    LE
  } estado_t;

  pedido_t       fila [PROFUNDIDADE_FILA];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   nivel;
  logic          cheia;
  logic          vazia;
  logic          aceita;
  logic          invalido;
  logic          push;
  logic          pop;

  estado_t       estado;
  estado_t       prox;
  logic [2:0]    src_r;
  logic [2:0]    dst_r;
  logic [CW-1:0] cnt;

  logic [5:0]    wr_oh;
  logic [5:0]    rd_oh;

  assign cheia = (nivel == CHEIO);
  assign vazia = (nivel == '0);

  // ready comes only from the registered level; held low during reset
  assign bus.req_ready = rst_n & ~cheia;
  assign aceita = bus.req_valid & bus.req_ready;

  assign invalido = (bus.req_src > 3'd5)
                  | (bus.req_dst > 3'd5)
                  | (bus.req_src == bus.req_dst);

  assign push = aceita & ~invalido;

  // a new transfer is loaded from OCIOSO or straight out of LE
  assign pop = ((estado == OCIOSO) | (estado == LE)) & ~vazia;

  // request FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      nivel  <= '0;
      for (int i = 0; i < PROFUNDIDADE_FILA; i++) begin
        fila[i] <= '0;
      end
    end else begin
      if (push) begin
        fila[wr_ptr] <= {bus.req_src, bus.req_dst};
        wr_ptr       <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        nivel <= nivel + 1'b1;
      end else if (pop && !push) begin
        nivel <= nivel - 1'b1;
      end
    end
  end

  // rejected requests flag one cycle after the accept edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      erro <= 1'b0;
    end else begin
      erro <= aceita & invalido;
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado <= OCIOSO;
    end else begin
      estado <= prox;
    end
  end

  // transfer registers and ESPERA down-counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_r <= '0;
      dst_r <= '0;
      cnt   <= '0;
    end else begin
      if (pop) begin
        src_r <= fila[rd_ptr].src;
        dst_r <= fila[rd_ptr].dst;
      end
      if (estado == ESCREVE) begin
        cnt <= CNT_INI;
      end else if (estado == ESPERA && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // next state
  always_comb begin
    prox = estado;
    unique case (estado)
      OCIOSO: begin
        if (!vazia) prox = ESCREVE;
      end
      ESCREVE: begin
        prox = (LATENCIA_BUS == 1) ? LE : ESPERA;
      end
      ESPERA: begin
        if (cnt == '0) prox = LE;
      end
      LE: begin
        prox = vazia ? OCIOSO : ESCREVE;
      end
      default: prox = OCIOSO;
    endcase
  end

  // outputs decoded from registered state only
  always_comb begin
    wr_oh = '0;
    rd_oh = '0;
    feito = 1'b0;
    unique case (1'b1)
      (estado == ESCREVE): begin
        wr_oh = 6'd1 << src_r;
      end
      (estado == LE): begin
        rd_oh = 6'd1 << dst_r;
        feito = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus.ctrl_0 = {wr_oh[0], rd_oh[0]};
  assign bus.ctrl_1 = {wr_oh[1], rd_oh[1]};
  assign bus.ctrl_2 = {wr_oh[2], rd_oh[2]};
  assign bus.ctrl_3 = {wr_oh[3], rd_oh[3]};
  assign bus.ctrl_4 = {wr_oh[4], rd_oh[4]};
  assign bus.ctrl_5 = {wr_oh[5], rd_oh[5]};

  assign ocupado    = (estado != OCIOSO) | ~vazia;
  assign nivel_fila = nivel;

  a_wr_onehot: assert property (
    @(posedge clk) disable iff (!rst_n) $onehot0(wr_oh));

  a_rd_onehot: assert property (
    @(posedge clk) disable iff (!rst_n) $onehot0(rd_oh));

  a_no_both: assert property (
    @(posedge clk) disable iff (!rst_n) (wr_oh & rd_oh) == '0);

  a_nivel: assert property (
    @(posedge clk) disable iff (!rst_n) nivel <= CHEIO);

endmodule

// File: tb/tb_controle_barramento.sv
// Self-checking bench for controle_barramento: vector table, hand sequences,
// bus data model and randomized traffic against a transfer-schedule model.
module tb_controle_barramento;

  localparam int DEPTH = 4;
  localparam int LAT   = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ocupado;
  logic       feito;
  logic       erro;
  logic [2:0] nivel_fila;

  controle_barramento_if bif();

  controle_barramento #(
    .PROFUNDIDADE_FILA(DEPTH),
    .LATENCIA_BUS(LAT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bif.slave),
    .ocupado(ocupado),
    .feito(feito),
    .erro(erro),
    .nivel_fila(nivel_fila)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int t = 0;

  // model: each accepted valid request becomes a scheduled transfer
  typedef struct {
    int src;
    int dst;
    int e;
    int s;
  } xfer_t;

  xfer_t xq[$];
  int    last_le = -100;
  int    err_t = -100;
  bit    log_on = 0;
  int    flog[$];

  function automatic logic [11:0] ctrl_vec();
    return {bif.ctrl_5, bif.ctrl_4, bif.ctrl_3,
            bif.ctrl_2, bif.ctrl_1, bif.ctrl_0};
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0d: got %0h, expected %0h",
               nm, t, act, exp);
    end
  endtask

  // queue occupancy in interval n: accepted, not yet popped
  function automatic int lvl(input int n);
    int c = 0;
    foreach (xq[i]) begin
      if (xq[i].e <= n && n < xq[i].s) c++;
    end
    return c;
  endfunction

  task automatic model_reset();
    xq.delete();
    last_le = -100;
    err_t = -100;
    t = 0;
  endtask

  task automatic model_check();
    logic [11:0] ev;
    bit ef;
    bit eo;
    int l;
    ev = '0;
    ef = 0;
    eo = 0;
    l = lvl(t);
    foreach (xq[i]) begin
      if (xq[i].s == t) ev[2*xq[i].src+1] = 1'b1;
      if (xq[i].s + LAT == t) begin
        ev[2*xq[i].dst] = 1'b1;
        ef = 1;
      end
      if (xq[i].s <= t && t <= xq[i].s + LAT) eo = 1;
    end
    eo = eo | (l > 0);
    chk("m_ctrl", ctrl_vec(), ev);
    chk("m_feito", feito, ef);
    chk("m_erro", erro, err_t == t);
    chk("m_nivel", nivel_fila, l);
    chk("m_ready", bif.req_ready, l < DEPTH);
    chk("m_ocupado", ocupado, eo);
  endtask

  // drive one interval, step past the edge, update model and compare
  task automatic cyc(input bit v, input int s, input int d);
    bit rdy;
    rdy = lvl(t) < DEPTH;
    bif.req_valid = v;
    bif.req_src = 3'(s);
    bif.req_dst = 3'(d);
    @(posedge clk);
    #1;
    t++;
    if (v && rdy) begin
      if (s > 5 || d > 5 || s == d) begin
        err_t = t;
      end else begin
        int st;
        st = ((t > last_le) ? t : last_le) + 1;
        xq.push_back('{s, d, t, st});
        last_le = st + LAT;
      end
    end
    while (xq.size() > 0 && xq[0].s + LAT < t - 1) begin
      void'(xq.pop_front());
    end
    if (log_on && feito === 1'b1) flog.push_back(t);
    model_check();
  endtask

  // bus model: ctrl sampled mid-cycle, two register stages
  logic [11:0] ctrl_s = '0;
  logic [15:0] port_d [6];
  logic [15:0] port_q [6];
  logic [15:0] stage1;
  logic [15:0] stage2;
  logic [15:0] bus_in;

  always @(negedge clk) begin
    logic [11:0] c;
    int nw;
    int nr;
    bit both;
    c = ctrl_vec();
    nw = 0;
    nr = 0;
    both = 0;
    for (int i = 0; i < 6; i++) begin
      if (c[2*i+1]) nw++;
      if (c[2*i]) nr++;
      if (c[2*i+1] && c[2*i]) both = 1;
    end
    chk("onehot", (nw <= 1 && nr <= 1 && !both), 1);
    ctrl_s <= c;
  end

  always_comb begin
    bus_in = '0;
    for (int i = 0; i < 6; i++) begin
      if (ctrl_s[2*i+1]) bus_in = port_d[i];
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage1 <= '0;
      stage2 <= '0;
      for (int i = 0; i < 6; i++) port_q[i] <= '0;
    end else begin
      stage1 <= bus_in;
      stage2 <= stage1;
      for (int i = 0; i < 6; i++) begin
        if (ctrl_s[2*i]) port_q[i] <= stage2;
      end
    end
  end

  typedef struct {
    logic [2:0]  src;
    logic [2:0]  dst;
    bit          err;
    logic [11:0] w;
    logic [11:0] r;
    bit          f;
  } vec_t;

  vec_t tab[9];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int e;
    int tries;
    bit acc;
    int ps[6];
    int pd[6];

    tab[0] = '{3'd1, 3'd4, 1'b0, 12'h008, 12'h100, 1'b1};
    tab[1] = '{3'd2, 3'd0, 1'b0, 12'h020, 12'h001, 1'b1};
    tab[2] = '{3'd5, 3'd3, 1'b0, 12'h800, 12'h040, 1'b1};
    tab[3] = '{3'd0, 3'd5, 1'b0, 12'h002, 12'h400, 1'b1};
    tab[4] = '{3'd4, 3'd2, 1'b0, 12'h200, 12'h010, 1'b1};
    tab[5] = '{3'd3, 3'd3, 1'b1, 12'h000, 12'h000, 1'b0};
    tab[6] = '{3'd6, 3'd0, 1'b1, 12'h000, 12'h000, 1'b0};
    tab[7] = '{3'd0, 3'd7, 1'b1, 12'h000, 12'h000, 1'b0};
    tab[8] = '{3'd7, 3'd7, 1'b1, 12'h000, 12'h000, 1'b0};

    for (int i = 0; i < 6; i++) port_d[i] = 16'h1000 + 16'(i);
    port_d[2] = 16'h00A5;

    bif.req_valid = 1'b0;
    bif.req_src = '0;
    bif.req_dst = '0;

    // reset state
    @(posedge clk);
    #1;
    chk("rst_ctrl", ctrl_vec(), 0);
    chk("rst_ready", bif.req_ready, 0);
    chk("rst_ocupado", ocupado, 0);
    chk("rst_feito", feito, 0);
    chk("rst_erro", erro, 0);
    chk("rst_nivel", nivel_fila, 0);
    rst_n = 1'b1;
    model_reset();
    #1;
    chk("ready_after_rst", bif.req_ready, 1);

    // single transfers from idle
    for (int i = 0; i < 9; i++) begin
      cyc(1, int'(tab[i].src), int'(tab[i].dst));
      e = t;
      chk("tab_erro", erro, tab[i].err);
      chk("tab_ctrl_e0", ctrl_vec(), 0);
      cyc(0, 0, 0);
      chk("tab_wr", ctrl_vec(), tab[i].w);
      cyc(0, 0, 0);
      chk("tab_wait", ctrl_vec(), 0);
      cyc(0, 0, 0);
      chk("tab_rd", ctrl_vec(), tab[i].r);
      chk("tab_feito", feito, tab[i].f);
      cyc(0, 0, 0);
      chk("tab_ocupado", ocupado, 0);
    end

    // fill the FIFO back-to-back, then offer one more while full
    ps = '{0, 1, 2, 3, 4, 5};
    pd = '{1, 2, 3, 4, 5, 0};
    flog.delete();
    log_on = 1;
    for (int k = 0; k < 6; k++) cyc(1, ps[k], pd[k]);
    chk("full_nivel", nivel_fila, 4);
    chk("full_ready", bif.req_ready, 0);
    tries = 0;
    acc = 0;
    while (!acc && tries < 10) begin
      acc = lvl(t) < DEPTH;
      cyc(1, 1, 3);
      tries++;
      chk("nivel_max", nivel_fila <= 4, 1);
    end
    chk("full_wait", tries, 3);
    tries = 0;
    while (xq.size() > 0 && tries < 60) begin
      cyc(0, 0, 0);
      tries++;
      chk("nivel_max", nivel_fila <= 4, 1);
    end
    chk("drain_bound", xq.size(), 0);
    log_on = 0;
    chk("feito_count", flog.size(), 7);
    for (int i = 1; i < flog.size(); i++) begin
      chk("feito_gap", flog[i] - flog[i-1], 3);
    end

    // invalid requests back to back
    cyc(1, 3, 3);
    chk("inv_erro_a", erro, 1);
    cyc(1, 6, 0);
    chk("inv_erro_b", erro, 1);
    cyc(0, 0, 0);
    chk("inv_erro_end", erro, 0);
    chk("inv_nivel", nivel_fila, 0);
    chk("inv_ctrl", ctrl_vec(), 0);
    repeat (3) cyc(0, 0, 0);

    // reset during ESCREVE of 3->1
    cyc(1, 3, 1);
    cyc(0, 0, 0);
    chk("esc_ctrl", ctrl_vec(), 12'h080);
    rst_n = 1'b0;
    #1;
    chk("esc_rst_ctrl", ctrl_vec(), 0);
    chk("esc_rst_ocupado", ocupado, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    // reset during ESPERA of 0->5
    cyc(1, 0, 5);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("esp_ocupado", ocupado, 1);
    rst_n = 1'b0;
    #1;
    chk("esp_rst_ctrl", ctrl_vec(), 0);
    chk("esp_rst_feito", feito, 0);
    chk("esp_rst_nivel", nivel_fila, 0);
    chk("esp_rst_ocupado", ocupado, 0);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("esp_hold_feito", feito, 0);
    end
    rst_n = 1'b1;
    model_reset();
    repeat (5) begin
      cyc(0, 0, 0);
      chk("post_rst_feito", feito, 0);
    end

    // data through the bus model: port 2 -> port 0
    chk("bus_before", port_q[0], 16'h0000);
    cyc(1, 2, 0);
    repeat (5) cyc(0, 0, 0);
    chk("bus_data", port_q[0], 16'h00A5);

    // randomized traffic
    repeat (400) begin
      bit v;
      int s;
      int d;
      v = $urandom_range(0, 9) < 7;
      s = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7))
                                      : int'($urandom_range(0, 5));
      d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7))
                                      : int'($urandom_range(0, 5));
      cyc(v, s, d);
    end
    repeat (20) cyc(0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
